// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the single-cycle RV32 core.
// Owns the program counter, fetches one instruction at a time over a
// req/gnt/rvalid handshake, and holds it while the core executes it.
//
// Ports:
//   clk, reset        core clock; active-low synchronous reset
//   imem_req/addr     fetch request (held until granted) and address (= PC)
//   imem_gnt/rvalid   request accepted / read data valid this cycle
//   imem_rdata        fetched instruction word
//   stall             hold the executing instruction
//   PCSrc             next-PC select: 00 PC+4, 01 PC+ImmExt, 10 JALR, 11 PC+4
//   ImmExt, ALUResult branch offset and JALR target
//   INSTRUCTION       held instruction word, qualified by instr_valid
//   PC, PCPlus4       address of INSTRUCTION and PC+4
//   misaligned        sticky flag: a next-PC target was not word aligned
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic [31:0] INSTRUCTION,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        misaligned
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC select; JALR clears bit 0 of the target.
  always_comb begin
    next_pc = pc_plus4;
    case (PCSrc)
      2'b01:   next_pc = pc_q + ImmExt;
      2'b10:   next_pc = ALUResult & 32'hFFFF_FFFE;
      default: next_pc = pc_plus4;
    endcase
  end

  // Fetch sequencing: one outstanding request, one instruction in flight.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    misaligned_d = misaligned_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end else begin
            misaligned_d = 1'b1;
            state_d      = ST_HALT;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign instr_valid = (state_q == ST_EXEC);
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign INSTRUCTION = instr_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written multi-cycle sequences.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic [31:0] INSTRUCTION;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .INSTRUCTION(INSTRUCTION), .instr_valid(instr_valid),
    .PC(PC), .PCPlus4(PCPlus4), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stl;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic g, input logic v, input logic [31:0] d,
                     input logic s, input logic [1:0] src, input logic [31:0] imm,
                     input logic [31:0] alu, input logic e_req, input logic e_valid,
                     input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_mis);
    vec_t t;
    t.rst_n = r; t.gnt = g; t.rv = v; t.rdata = d; t.stl = s; t.src = src;
    t.imm = imm; t.alu = alu; t.e_req = e_req; t.e_valid = e_valid;
    t.e_pc = e_pc; t.e_instr = e_instr; t.e_mis = e_mis;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic e_valid,
                           input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic e_mis);
    chk({tag, ".req"},   32'(imem_req),    32'(e_req));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
    chk({tag, ".pc"},    PC,               e_pc);
    chk({tag, ".addr"},  imem_addr,        e_pc);
    chk({tag, ".pc4"},   PCPlus4,          e_pc + 32'd4);
    chk({tag, ".instr"}, INSTRUCTION,      e_instr);
    chk({tag, ".mis"},   32'(misaligned),  32'(e_mis));
  endtask

  // Drive inputs, then advance one rising edge and settle.
  task automatic drive(input logic r, input logic g, input logic v, input logic [31:0] d,
                       input logic s, input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] alu);
    reset = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    stall = s; PCSrc = src; ImmExt = imm; ALUResult = alu;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; PCSrc = 2'b00; ImmExt = '0; ALUResult = '0;

    //  rst g v rdata        stl src   imm           alu        req vld pc            instr        mis
    add(0, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     0,  0,  32'h0,        NOP,         0);
    add(0, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     0,  0,  32'h0,        NOP,         0);
    add(1, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     1,  0,  32'h0,        NOP,         0);
    add(1, 1, 1, 32'hA0,     0, 2'b00, 32'h0,        32'h0,     0,  1,  32'h0,        32'hA0,      0);
    add(1, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     1,  0,  32'h4,        32'hA0,      0);
    add(1, 1, 1, 32'hA1,     0, 2'b00, 32'h0,        32'h0,     0,  1,  32'h4,        32'hA1,      0);
    add(1, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     1,  0,  32'h8,        32'hA1,      0);
    add(1, 1, 1, 32'hA2,     0, 2'b00, 32'h0,        32'h0,     0,  1,  32'h8,        32'hA2,      0);
    add(1, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     1,  0,  32'hC,        32'hA2,      0);
    add(1, 1, 1, 32'hA3,     0, 2'b00, 32'h0,        32'h0,     0,  1,  32'hC,        32'hA3,      0);
    add(1, 0, 0, 32'h0,      0, 2'b01, 32'h4,        32'h0,     1,  0,  32'h10,       32'hA3,      0);
    add(1, 1, 1, 32'hA4,     0, 2'b00, 32'h0,        32'h0,     0,  1,  32'h10,       32'hA4,      0);
    add(1, 0, 0, 32'h0,      0, 2'b01, 32'hFFFFFFF8, 32'h0,     1,  0,  32'h8,        32'hA4,      0);
    add(1, 0, 1, BAD,        0, 2'b00, 32'h0,        32'h0,     1,  0,  32'h8,        32'hA4,      0);
    add(1, 1, 1, 32'hA5,     0, 2'b00, 32'h0,        32'h0,     0,  1,  32'h8,        32'hA5,      0);
    add(1, 0, 0, 32'h0,      0, 2'b10, 32'h0,        32'h101,   1,  0,  32'h100,      32'hA5,      0);
    add(1, 1, 1, 32'hA6,     0, 2'b00, 32'h0,        32'h0,     0,  1,  32'h100,      32'hA6,      0);
    add(1, 0, 0, 32'h0,      0, 2'b10, 32'h0,        32'h20,    1,  0,  32'h20,       32'hA6,      0);
    add(1, 1, 1, 32'hA7,     0, 2'b00, 32'h0,        32'h0,     0,  1,  32'h20,       32'hA7,      0);
    add(1, 0, 0, 32'h0,      0, 2'b01, 32'h6,        32'h0,     0,  0,  32'h20,       32'hA7,      1);
    add(1, 1, 1, BAD,        0, 2'b00, 32'h0,        32'h0,     0,  0,  32'h20,       32'hA7,      1);
    add(1, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     0,  0,  32'h20,       32'hA7,      1);
    add(0, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     0,  0,  32'h0,        NOP,         0);
    add(1, 0, 0, 32'h0,      0, 2'b00, 32'h0,        32'h0,     1,  0,  32'h0,        NOP,         0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].stl,
            vecs[i].src, vecs[i].imm, vecs[i].alu);
      check_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_valid,
                vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_mis);
    end

    // Variable latency from REQ at PC 0: gnt after 2 cycles, rvalid 3 cycles after gnt.
    drive(1, 0, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("lat.gw0", 1, 0, 32'h0, NOP, 0);
    drive(1, 0, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("lat.gw1", 1, 0, 32'h0, NOP, 0);
    drive(1, 1, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("lat.w0", 0, 0, 32'h0, NOP, 0);
    drive(1, 0, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("lat.w1", 0, 0, 32'h0, NOP, 0);
    drive(1, 0, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("lat.w2", 0, 0, 32'h0, NOP, 0);
    drive(1, 0, 1, 32'h00500093, 0, 2'b00, 32'h0, 32'h0);
    check_all("lat.exec", 0, 1, 32'h0, 32'h00500093, 0);

    // Stall for 3 cycles with PCSrc toggling and stray rvalid; release uses PCSrc=01.
    drive(1, 0, 1, BAD, 1, 2'b01, 32'h40, 32'h80);
    check_all("stl.0", 0, 1, 32'h0, 32'h00500093, 0);
    drive(1, 0, 0, 32'h0, 1, 2'b10, 32'h40, 32'h80);
    check_all("stl.1", 0, 1, 32'h0, 32'h00500093, 0);
    drive(1, 0, 1, BAD, 1, 2'b11, 32'h40, 32'h80);
    check_all("stl.2", 0, 1, 32'h0, 32'h00500093, 0);
    drive(1, 0, 0, 32'h0, 0, 2'b01, 32'h40, 32'h80);
    check_all("stl.rel", 1, 0, 32'h40, 32'h00500093, 0);

    // Wrap: JALR to 0xFFFFFFFC, then sequential fetch lands on 0.
    drive(1, 1, 1, 32'hB0, 0, 2'b00, 32'h0, 32'h0);
    check_all("wrap.e0", 0, 1, 32'h40, 32'hB0, 0);
    drive(1, 0, 0, 32'h0, 0, 2'b10, 32'h0, 32'hFFFFFFFC);
    check_all("wrap.r1", 1, 0, 32'hFFFFFFFC, 32'hB0, 0);
    drive(1, 1, 1, 32'hB1, 0, 2'b00, 32'h0, 32'h0);
    check_all("wrap.e1", 0, 1, 32'hFFFFFFFC, 32'hB1, 0);
    drive(1, 0, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("wrap.r2", 1, 0, 32'h0, 32'hB1, 0);

    // Reset during WAIT, with a response arriving in the reset cycle.
    drive(1, 1, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("rw.wait", 0, 0, 32'h0, 32'hB1, 0);
    drive(1, 0, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("rw.wait2", 0, 0, 32'h0, 32'hB1, 0);
    drive(0, 0, 1, BAD, 0, 2'b00, 32'h0, 32'h0);
    check_all("rw.rst", 0, 0, 32'h0, NOP, 0);
    drive(1, 0, 0, 32'h0, 0, 2'b00, 32'h0, 32'h0);
    check_all("rw.req", 1, 0, 32'h0, NOP, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode controller in the single-cycle RV32 core.
- Owns the program counter and fetches from instruction memory over a req/gnt/rvalid handshake with variable latency.
- Holds INSTRUCTION stable with instr_valid while the controller and datapath execute it.
- Computes the next PC from PCSrc, which the controller produces, and halts on a misaligned target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, INSTRUCTION value after reset (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  active-low synchronous reset.
- imem_req  output  1  fetch request, held until granted.
- imem_addr  output  32  fetch address; equals PC.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- stall  input  1  datapath holds the current instruction (e.g. data memory busy).
- PCSrc  input  2  next-PC select from the controller.
- ImmExt  input  32  sign-extended immediate from the datapath.
- ALUResult  input  32  ALU result, used as the JALR target.
- INSTRUCTION  output  32  instruction word to the controller and immediate extender.
- instr_valid  output  1  INSTRUCTION is valid and executing.
- PC  output  32  address of INSTRUCTION.
- PCPlus4  output  32  PC+4, used for the link-register writeback.
- misaligned  output  1  sticky fault flag: a next-PC target had [1:0] != 0.

Behaviour:
- Reset, sampled low at a clock edge:
  - state=IDLE, PC=RESET_PC, INSTRUCTION=NOP_INSTR, misaligned=0.
  - Consequently imem_req=0 and instr_valid=0.
  - Reset overrides every other input, in any state and mid-transaction.
- Instruction memory shares this reset and discards in-flight responses. The block tracks exactly one outstanding request.
- States: IDLE, REQ, WAIT, EXEC, HALT.
- imem_req = (state==REQ). instr_valid = (state==EXEC). Both are decoded from registered state, with no combinational path from inputs.
- imem_addr = PC at all times.
- IDLE:
  - Go to REQ unconditionally on the next cycle after reset deasserts.
- REQ:
  - imem_gnt=0: stay in REQ; PC and imem_addr stay stable.
  - imem_gnt=1 and imem_rvalid=1 (zero-latency memory): INSTRUCTION <= imem_rdata; go to EXEC.
  - imem_gnt=1 and imem_rvalid=0: go to WAIT.
  - imem_rvalid without imem_gnt: ignored.
- WAIT:
  - imem_rvalid=1: INSTRUCTION <= imem_rdata; go to EXEC.
  - Otherwise stay in WAIT; no timeout.
- EXEC:
  - stall=1: hold all state.
  - stall=0: compute next as follows.
    - PCSrc 2'b00: PC+4.
    - PCSrc 2'b01: PC+ImmExt (branch taken / JAL).
    - PCSrc 2'b10: {ALUResult[31:1],1'b0} (JALR).
    - PCSrc 2'b11: reserved, treated as PC+4.
  - If next[1:0]==2'b00: PC <= next; go to REQ.
  - Else: misaligned <= 1; PC unchanged; go to HALT.
  - INSTRUCTION keeps its last value outside EXEC; only instr_valid qualifies it.
- HALT:
  - Terminal until reset. No requests issued; imem_rvalid ignored.
- Arithmetic:
  - All adds are 32-bit, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
  - PCPlus4 = PC + 4, combinational from the PC register.
- Throughput: 2 cycles per instruction minimum (REQ, EXEC) with zero-latency memory. Add 1 cycle per gnt-wait cycle and 1 per WAIT cycle.
- imem_rvalid while in IDLE, EXEC or HALT: ignored; INSTRUCTION does not change.

Test Plan:
- Zero-latency sequential:
  - Stimulus: release reset; memory returns gnt+rvalid in the same cycle; PCSrc=00.
  - Required: PC sequence 0,4,8,C. instr_valid high every second cycle. imem_req first asserts 1 cycle after reset release.
- Variable latency:
  - Stimulus: gnt delayed 2 cycles, rvalid 3 cycles after gnt; rdata=32'h00500093.
  - Required: imem_addr is stable through REQ. INSTRUCTION=32'h00500093 with instr_valid rising exactly 1 cycle after rvalid.
- Branch/JALR:
  - Stimulus 1: PC=0x10, PCSrc=01, ImmExt=32'hFFFF_FFF8. Required: next fetch address 0x08.
  - Stimulus 2: PCSrc=10, ALUResult=0x101. Required: next fetch address 0x100.
- Stall:
  - Stimulus: stall=1 for 3 cycles in EXEC with PCSrc toggling.
  - Required: PC, INSTRUCTION and instr_valid unchanged; no imem_req. The fetch after stall drops uses the PCSrc sampled on the release cycle.
- Misaligned:
  - Stimulus: PCSrc=01, PC=0x20, ImmExt=0x6.
  - Required: misaligned=1, PC stays 0x20, state HALT. No further imem_req until reset; reset clears misaligned.
- Reset mid-WAIT and wrap:
  - Stimulus 1: reset asserted during WAIT. Required: next cycle imem_req=0, instr_valid=0, PC=RESET_PC, INSTRUCTION=32'h00000013.
  - Stimulus 2: PC=32'hFFFF_FFFC with PCSrc=00. Required: fetches address 0.
